// File: rtl/rstatus_ctrl_if.sv
// ---------------------------------------------------------------------------
// rstatus_ctrl_if
//   Bundles the exception-status controller signals.
//   slave  : seen by rstatus_ctrl (exception inputs in, status/debug out)
//   master : seen by the datapath / bench driving the exception sources
//
//   exc_valid    per-source exception pulse (already qualified upstream)
//   exc_mask     1 = source ignored entirely
//   wb_busy      register-file write port taken this cycle
//   clear_stat   clears sticky bits, counters and lost_evt
//   cnt_sel      per-source counter read select
//   rstatus_out  cause code written to the status register (zero-extended)
//   write_status one-cycle write enable for the status register
//   status_addr  status register index
//   sticky_cause accumulated unmasked events
//   pending      a deferred status write is held
//   lost_evt     sticky: an event was dropped or replaced
//   cnt_out      counter[cnt_sel], 0 when cnt_sel is out of range
// ---------------------------------------------------------------------------
interface rstatus_ctrl_if #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_SRC    = 4,
    parameter int CNT_WIDTH  = 8
) ();
    localparam int SEL_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    logic [NUM_SRC-1:0]    exc_valid;
    logic [NUM_SRC-1:0]    exc_mask;
    logic                  wb_busy;
    logic                  clear_stat;
    logic [SEL_W-1:0]      cnt_sel;
    logic [DATA_WIDTH-1:0] rstatus_out;
    logic                  write_status;
    logic [4:0]            status_addr;
    logic [NUM_SRC-1:0]    sticky_cause;
    logic                  pending;
    logic                  lost_evt;
    logic [CNT_WIDTH-1:0]  cnt_out;

    modport slave (
        input  exc_valid, exc_mask, wb_busy, clear_stat, cnt_sel,
        output rstatus_out, write_status, status_addr, sticky_cause,
               pending, lost_evt, cnt_out
    );

    modport master (
        output exc_valid, exc_mask, wb_busy, clear_stat, cnt_sel,
        input  rstatus_out, write_status, status_addr, sticky_cause,
               pending, lost_evt, cnt_out
    );
endinterface

// File: rtl/rstatus_ctrl.sv
// ---------------------------------------------------------------------------
// rstatus_ctrl
//   Exception-status controller for the single-cycle MIPS datapath.
//   NUM_SRC masked exception sources with fixed priority (lowest index wins,
//   cause code = index+1). The winning code is written to the status register
//   one cycle later, or deferred while the register-file write port is busy.
//   Also keeps sticky cause bits, saturating per-source event counters and a
//   lost-event flag.
//
//   clock : system clock, rising edge
//   reset : asynchronous, active-low
//   bus   : rstatus_ctrl_if.slave (see interface header for signal list)
// ---------------------------------------------------------------------------
module rstatus_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_SRC    = 4,
    parameter int CNT_WIDTH  = 8,
    parameter int STATUS_REG = 30
) (
    input  logic                clock,
    input  logic                reset,
    rstatus_ctrl_if.slave       bus
);
    localparam int SEL_W  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int CODE_W = $clog2(NUM_SRC + 1);

    typedef enum logic {IDLE, PEND} state_t;

    state_t                state_q, state_d;
    logic [NUM_SRC-1:0]    hit;
    logic [CODE_W-1:0]     win_code;
    logic [CODE_W-1:0]     pend_code;
    logic [CODE_W-1:0]     pend_nxt;
    logic [CODE_W-1:0]     write_code;
    logic                  any_hit;
    logic                  write_en;
    logic                  pend_load;
    logic                  lost_set;

    logic [DATA_WIDTH-1:0] rstatus_q;
    logic                  write_q;
    logic [NUM_SRC-1:0]    sticky_q;
    logic                  lost_q;
    logic [CNT_WIDTH-1:0]  cnt_q [NUM_SRC];

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign hit     = bus.exc_valid & ~bus.exc_mask;
    assign any_hit = |hit;

    // Scan from the top so the lowest set index is the last to assign.
    always_comb begin
        win_code = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (hit[i]) win_code = CODE_W'(i + 1);
        end
    end

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (any_hit && bus.wb_busy)    state_d = PEND;
            PEND: if (!bus.wb_busy && !any_hit)  state_d = IDLE;
            default:                             state_d = IDLE;
        endcase
    end

    // Output / datapath-control logic
    always_comb begin
        write_en   = 1'b0;
        write_code = '0;
        pend_load  = 1'b0;
        pend_nxt   = win_code;
        lost_set   = 1'b0;
        case (state_q)
            IDLE: begin
                if (any_hit) begin
                    if (bus.wb_busy) pend_load = 1'b1;
                    else begin
                        write_en   = 1'b1;
                        write_code = win_code;
                    end
                end
            end
            PEND: begin
                if (!bus.wb_busy) begin
                    write_en   = 1'b1;
                    write_code = pend_code;
                    pend_load  = any_hit;
                end else if (any_hit) begin
                    // Only a higher-priority (smaller) code displaces the held one.
                    lost_set  = 1'b1;
                    pend_load = (win_code < pend_code);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rstatus_q <= '0;
            write_q   <= 1'b0;
            pend_code <= '0;
            sticky_q  <= '0;
            lost_q    <= 1'b0;
            for (int i = 0; i < NUM_SRC; i++) cnt_q[i] <= '0;
        end else begin
            write_q <= write_en;
            if (write_en)  rstatus_q <= DATA_WIDTH'(write_code);
            if (pend_load) pend_code <= pend_nxt;
            // clear_stat keeps only this cycle's new events.
            sticky_q <= (bus.clear_stat ? '0 : sticky_q) | hit;
            lost_q   <= (bus.clear_stat ? 1'b0 : lost_q) | lost_set;
            for (int i = 0; i < NUM_SRC; i++) begin
                if (hit[i])
                    cnt_q[i] <= sat_inc(bus.clear_stat ? '0 : cnt_q[i]);
                else if (bus.clear_stat)
                    cnt_q[i] <= '0;
            end
        end
    end

    always_comb begin
        bus.cnt_out = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (bus.cnt_sel == SEL_W'(i)) bus.cnt_out = cnt_q[i];
        end
    end

    assign bus.rstatus_out  = rstatus_q;
    assign bus.write_status = write_q;
    assign bus.status_addr  = 5'(STATUS_REG);
    assign bus.sticky_cause = sticky_q;
    assign bus.pending      = (state_q == PEND);
    assign bus.lost_evt     = lost_q;
endmodule

// File: tb/tb_rstatus_ctrl.sv
module tb_rstatus_ctrl;
    logic clock;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    rstatus_ctrl_if #(.DATA_WIDTH(32), .NUM_SRC(4), .CNT_WIDTH(8)) bus ();
    rstatus_ctrl_if #(.DATA_WIDTH(32), .NUM_SRC(4), .CNT_WIDTH(2)) bus2 ();

    rstatus_ctrl #(.DATA_WIDTH(32), .NUM_SRC(4), .CNT_WIDTH(8), .STATUS_REG(30)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    rstatus_ctrl #(.DATA_WIDTH(32), .NUM_SRC(4), .CNT_WIDTH(2), .STATUS_REG(30)) dut2 (
        .clock (clock),
        .reset (reset),
        .bus   (bus2.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        step();
        reset = 1'b1;
    endtask

    task automatic idle_inputs();
        bus.exc_valid  = '0;
        bus.exc_mask   = '0;
        bus.wb_busy    = 1'b0;
        bus.clear_stat = 1'b0;
        bus.cnt_sel    = '0;
    endtask

    task automatic read_cnt(input logic [1:0] sel, input logic [7:0] exp, input string tag);
        bus.cnt_sel = sel;
        #1;
        check(tag, bus.cnt_out, exp);
    endtask

    initial begin
        reset = 1'b0;
        idle_inputs();
        bus2.exc_valid  = '0;
        bus2.exc_mask   = '0;
        bus2.wb_busy    = 1'b0;
        bus2.clear_stat = 1'b0;
        bus2.cnt_sel    = '0;
        step();
        check("rst_rstatus", bus.rstatus_out, 0);
        check("rst_write",   bus.write_status, 0);
        check("rst_sticky",  bus.sticky_cause, 0);
        check("rst_pending", bus.pending, 0);
        check("rst_lost",    bus.lost_evt, 0);
        check("rst_cnt0",    bus.cnt_out, 0);
        reset = 1'b1;

        // 1: single hit, port free
        bus.exc_valid = 4'b0001;
        step();
        check("t1_write",   bus.write_status, 1);
        check("t1_rstatus", bus.rstatus_out, 1);
        check("t1_addr",    bus.status_addr, 30);
        check("t1_sticky",  bus.sticky_cause, 4'b0001);
        check("t1_cnt0",    bus.cnt_out, 1);
        bus.exc_valid = '0;
        step();
        check("t1_write_n2", bus.write_status, 0);
        check("t1_hold",     bus.rstatus_out, 1);

        // 2: simultaneous hits, lowest index wins
        do_reset();
        bus.exc_valid = 4'b0110;
        step();
        check("t2_write",   bus.write_status, 1);
        check("t2_rstatus", bus.rstatus_out, 2);
        check("t2_sticky",  bus.sticky_cause, 4'b0110);
        bus.exc_valid = '0;
        step();
        check("t2_single", bus.write_status, 0);
        read_cnt(2'd0, 8'd0, "t2_cnt0");
        read_cnt(2'd1, 8'd1, "t2_cnt1");
        read_cnt(2'd2, 8'd1, "t2_cnt2");
        read_cnt(2'd3, 8'd0, "t2_cnt3");

        // 3: deferred write replaced by higher priority
        do_reset();
        bus.wb_busy   = 1'b1;
        bus.exc_valid = 4'b0100;
        step();
        check("t3_pend_a",  bus.pending, 1);
        check("t3_nowr_a",  bus.write_status, 0);
        bus.exc_valid = '0;
        step();
        check("t3_pend_b",  bus.pending, 1);
        check("t3_lost_b",  bus.lost_evt, 0);
        bus.exc_valid = 4'b0010;
        step();
        check("t3_pend_c",  bus.pending, 1);
        check("t3_lost_c",  bus.lost_evt, 1);
        check("t3_nowr_c",  bus.write_status, 0);
        bus.exc_valid = '0;
        bus.wb_busy   = 1'b0;
        step();
        check("t3_write",   bus.write_status, 1);
        check("t3_rstatus", bus.rstatus_out, 2);
        check("t3_pend_d",  bus.pending, 0);
        step();
        check("t3_one_wr",  bus.write_status, 0);

        // 3b: lower-priority hit while busy is discarded
        do_reset();
        bus.wb_busy   = 1'b1;
        bus.exc_valid = 4'b0010;
        step();
        bus.exc_valid = 4'b1000;
        step();
        check("t3b_lost", bus.lost_evt, 1);
        bus.exc_valid = '0;
        bus.wb_busy   = 1'b0;
        step();
        check("t3b_write",   bus.write_status, 1);
        check("t3b_rstatus", bus.rstatus_out, 2);
        check("t3b_pend",    bus.pending, 0);

        // 3c: port frees with a new hit: emit held code, new one stays pending
        do_reset();
        bus.wb_busy   = 1'b1;
        bus.exc_valid = 4'b0001;
        step();
        bus.wb_busy   = 1'b0;
        bus.exc_valid = 4'b0100;
        step();
        check("t3c_write_a",   bus.write_status, 1);
        check("t3c_rstatus_a", bus.rstatus_out, 1);
        check("t3c_pend_a",    bus.pending, 1);
        check("t3c_lost_a",    bus.lost_evt, 0);
        bus.exc_valid = '0;
        step();
        check("t3c_write_b",   bus.write_status, 1);
        check("t3c_rstatus_b", bus.rstatus_out, 3);
        check("t3c_pend_b",    bus.pending, 0);
        step();
        check("t3c_write_c",   bus.write_status, 0);

        // 4: masked source has no effect; saturation on narrow counters
        do_reset();
        bus.exc_mask  = 4'b0001;
        bus.exc_valid = 4'b0001;
        bus2.exc_valid = 4'b0010;
        bus2.cnt_sel   = 2'd1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("t4_nowrite", bus.write_status, 0);
        end
        check("t4_sticky", bus.sticky_cause, 0);
        read_cnt(2'd0, 8'd0, "t4_cnt0");
        step();
        bus2.exc_valid = '0;
        check("t4_sat_cnt1", bus2.cnt_out, 3);
        step();
        check("t4_sat_hold", bus2.cnt_out, 3);
        idle_inputs();

        // 5: clear_stat together with a new hit
        do_reset();
        bus.wb_busy   = 1'b1;
        bus.exc_valid = 4'b0001;
        step();
        bus.exc_valid = 4'b0010;
        step();
        check("t5_pre_lost",   bus.lost_evt, 1);
        check("t5_pre_sticky", bus.sticky_cause, 4'b0011);
        bus.wb_busy    = 1'b0;
        bus.clear_stat = 1'b1;
        bus.exc_valid  = 4'b1000;
        step();
        bus.clear_stat = 1'b0;
        bus.exc_valid  = '0;
        check("t5_sticky",  bus.sticky_cause, 4'b1000);
        check("t5_lost",    bus.lost_evt, 0);
        check("t5_write",   bus.write_status, 1);
        check("t5_rstatus", bus.rstatus_out, 1);
        check("t5_pend",    bus.pending, 1);
        read_cnt(2'd3, 8'd1, "t5_cnt3");
        read_cnt(2'd0, 8'd0, "t5_cnt0");
        read_cnt(2'd1, 8'd0, "t5_cnt1");
        read_cnt(2'd2, 8'd0, "t5_cnt2");
        step();
        check("t5_write_b",   bus.write_status, 1);
        check("t5_rstatus_b", bus.rstatus_out, 4);

        // 6: reset while a write is pending
        do_reset();
        bus.wb_busy   = 1'b1;
        bus.exc_valid = 4'b0100;
        step();
        bus.exc_valid = '0;
        check("t6_pend", bus.pending, 1);
        reset = 1'b0;
        #1;
        check("t6_async_pend",   bus.pending, 0);
        check("t6_async_sticky", bus.sticky_cause, 0);
        step();
        bus.wb_busy = 1'b0;
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("t6_nowrite", bus.write_status, 0);
            check("t6_nopend",  bus.pending, 0);
        end
        check("t6_rstatus", bus.rstatus_out, 0);
        check("t6_lost",    bus.lost_evt, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/rstatus_ctrl.md
Name: rstatus_ctrl

Overview:
- Parametrised exception-status controller for the single-cycle MIPS datapath.
- Generalises the fixed add/sub/addi overflow decode to NUM_SRC masked exception sources with fixed priority.
- Produces a registered write of the cause code into the status register ($r30 by default) and defers that write while the register-file write port is busy (e.g. multdiv writeback).
- Keeps sticky cause bits, per-source saturating event counters and a lost-event flag for debug/trap software.

Parameters:
- DATA_WIDTH, 32: width of rstatus_out.
- NUM_SRC, 4: number of exception sources. Source i reports cause code i+1.
- CNT_WIDTH, 8: width of each per-source saturating counter.
- STATUS_REG, 30: register index driven on status_addr.

Ports:
- clock  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- exc_valid  input  NUM_SRC  per-source exception pulse, already qualified upstream (rd != 0, overflow, opcode).
- exc_mask  input  NUM_SRC  1 = source ignored entirely: no write, no sticky, no count.
- wb_busy  input  1  1 = register-file write port taken this cycle.
- clear_stat  input  1  clears sticky_cause, counters and lost_evt.
- cnt_sel  input  clog2(NUM_SRC) (min 1)  counter read select.
- rstatus_out  output  DATA_WIDTH  cause code to write; zero-extended.
- write_status  output  1  one-cycle write-enable pulse for the status register.
- status_addr  output  5  constant STATUS_REG.
- sticky_cause  output  NUM_SRC  accumulated unmasked events.
- pending  output  1  a deferred status write is held.
- lost_evt  output  1  sticky; set when an event is dropped or replaced.
- cnt_out  output  CNT_WIDTH  counter[cnt_sel], combinational; 0 if cnt_sel >= NUM_SRC.

Behaviour:
- Reset (reset=0, asynchronous): every output register goes to 0 (rstatus_out, write_status, sticky_cause, pending, lost_evt, all counters); FSM enters IDLE.
- hit = exc_valid & ~exc_mask. The winner is the lowest set index; win_code = index+1. Simultaneous non-winning hits still update sticky bits and counters, but produce no write.
- rstatus_out and write_status are registered. rstatus_out holds its last written value between writes. write_status is high for exactly one cycle per write.
- FSM IDLE:
  - hit at cycle N with wb_busy=0: write_status=1 and rstatus_out=win_code in cycle N+1; stay IDLE.
  - hit at cycle N with wb_busy=1: latch win_code into pend_code; go to PEND (pending=1 from N+1).
- FSM PEND, per cycle:
  - wb_busy=0: emit pend_code (write_status=1 next cycle). If there is a new hit in the same cycle, it becomes the new pend_code and the FSM stays PEND; otherwise return to IDLE.
  - wb_busy=1 with a new hit: a higher-priority win_code (smaller code) replaces pend_code; otherwise the new hit is discarded. Either way lost_evt is set.
  - wb_busy=1, no hit: hold.
- Counters: increment by 1 per cycle while the source's hit bit is set; saturate at 2^CNT_WIDTH-1 (no wrap).
- clear_stat: sticky bits, counters and lost_evt take their new-event value only. A hit in the same cycle as clear_stat sets its sticky bit and its counter becomes 1. clear_stat does not affect the FSM, pending or rstatus_out.
- exc_mask changes take effect in the same cycle. Masking does not cancel an already pending write.
- Reset asserted mid-PEND: the pending write is discarded; no write_status after reset release until a new hit.
- rstatus_out bits above the code width are 0. NUM_SRC must be <= 2^DATA_WIDTH-1.

Test Plan:
1. Reset, then exc_valid=0001, wb_busy=0 at cycle N -> cycle N+1: write_status=1, rstatus_out=1, status_addr=30, sticky_cause=0001, cnt_out (sel 0)=1. Cycle N+2: write_status=0.
2. exc_valid=0110 in one cycle -> rstatus_out=2, single write pulse, sticky_cause=0110, counters 1 and 2 each =1.
3. wb_busy=1; exc_valid=0100 at N; wb_busy held 3 cycles; exc_valid=0010 at N+2 -> pending=1, pend_code replaced by 2, lost_evt=1. After wb_busy drops: exactly one write with rstatus_out=2; pending=0.
4. exc_mask=0001 with exc_valid=0001 for 5 cycles -> no write_status, sticky=0, counter0=0. Then CNT_WIDTH=2 build, source 1 held 6 cycles -> counter1=3 (saturated).
5. clear_stat with exc_valid=1000 in the same cycle -> sticky_cause=1000, counter3=1, all other counters 0, lost_evt=0.
6. PEND with code 3 held; assert reset for 1 cycle; release with wb_busy=0 -> all outputs 0 and no write_status in the following 5 cycles.
